// File: rtl/data_mem_ls.sv
// Byte-addressable data memory with load/store unit: b/h/w access, sign/zero extend, 1-cycle response.
// Define DATA_MEM_MISALIGN_EN to split word-crossing accesses into two beats; otherwise misaligned faults.
module data_mem_ls #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_fault
);
    localparam int BW    = DATA_WIDTH / 4;
    localparam int WA    = ADDR_WIDTH - 2;
    localparam int DEPTH = 2 ** WA;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SPLIT = 1'b1;

    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        case (sz)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            2'b10:   return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    logic [0:0]            state;
    logic                  in_split, accept, fault, split_go;
    logic [WA-1:0]         req_widx, c_widx1, acc_widx;
    logic [1:0]            c_off, c_size, act_off, act_size;
    logic                  c_we, c_uns, act_we, act_uns;
    logic [3:0][BW-1:0]    c_wdata, act_wdata, rd_lane, hold, merged, lb;
    logic [DATA_WIDTH-1:0] load_val;

    assign in_split  = (state == SPLIT);
    assign req_ready = (state == IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign req_widx  = req_addr[ADDR_WIDTH-1:2];

`ifdef DATA_MEM_MISALIGN_EN
    logic crosses;
    assign crosses  = ({1'b0, req_addr[1:0]} + size_bytes(req_size)) > 3'd4;
    assign fault    = (req_size == 2'b11);
    assign split_go = crosses;
`else
    logic misal;
    assign misal    = (req_size == 2'b01 && req_addr[0]) ||
                      (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    assign fault    = (req_size == 2'b11) || misal;
    assign split_go = 1'b0;
`endif

    // During SPLIT the captured request drives the datapath; the live port is ignored.
    assign act_off   = in_split ? c_off    : req_addr[1:0];
    assign act_size  = in_split ? c_size   : req_size;
    assign act_we    = in_split ? c_we     : req_we;
    assign act_uns   = in_split ? c_uns    : req_unsigned;
    assign act_wdata = in_split ? c_wdata  : req_wdata;
    assign acc_widx  = in_split ? c_widx1  : req_widx;

    for (genvar l = 0; l < 4; l++) begin : g_lane
        logic [BW-1:0] mem [DEPTH];
        logic [1:0]    j;
        logic          in_acc, first_word, we;

        // Lanes at or above the offset belong to word W, lanes below it to W+1.
        assign j          = 2'(l) - act_off;
        assign in_acc     = {1'b0, j} < size_bytes(act_size);
        assign first_word = 2'(l) >= act_off;
        assign we         = act_we && in_acc &&
                            (in_split ? !first_word : (accept && !fault && first_word));

        always_ff @(posedge clk) begin
            if (we) mem[acc_widx] <= act_wdata[j];
        end

        assign rd_lane[l] = mem[acc_widx];
        assign merged[l]  = (in_split && first_word) ? hold[l] : rd_lane[l];
    end

    always_ff @(posedge clk) begin
        if (accept) hold <= rd_lane;
    end

    always_comb begin
        for (int k = 0; k < 4; k++) lb[k] = merged[act_off + 2'(k)];
        case (act_size)
            2'b00:   load_val = {{(DATA_WIDTH-BW){!act_uns && lb[0][BW-1]}}, lb[0]};
            2'b01:   load_val = {{(DATA_WIDTH-2*BW){!act_uns && lb[1][BW-1]}}, lb[1], lb[0]};
            default: load_val = lb;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_fault <= 1'b0;
            c_off     <= '0;
            c_size    <= '0;
            c_we      <= 1'b0;
            c_uns     <= 1'b0;
            c_wdata   <= '0;
            c_widx1   <= '0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_fault <= 1'b0;
            rsp_rdata <= '0;
            if (in_split) begin
                state     <= IDLE;
                rsp_valid <= 1'b1;
                rsp_rdata <= c_we ? '0 : load_val;
            end else if (accept) begin
                if (split_go) begin
                    state   <= SPLIT;
                    c_off   <= req_addr[1:0];
                    c_size  <= req_size;
                    c_we    <= req_we;
                    c_uns   <= req_unsigned;
                    c_wdata <= req_wdata;
                    c_widx1 <= req_widx + WA'(1);
                end else begin
                    rsp_valid <= 1'b1;
                    rsp_fault <= fault;
                    rsp_rdata <= (fault || req_we) ? '0 : load_val;
                end
            end
        end
    end
endmodule

// File: tb/tb_data_mem_ls.sv
// Self-checking bench for data_mem_ls: byte-level memory model, per-cycle compare, directed + random.
module tb_data_mem_ls;
    localparam int AW = 17;
    localparam int DW = 32;

    logic          clk = 1'b0, rst = 1'b0;
    logic          req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
    logic [1:0]    req_size = 2'b00;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          req_ready, rsp_valid, rsp_fault;
    logic [DW-1:0] rsp_rdata;

    int checks = 0, errors = 0, edges = 0, busy_edge = -1;
    logic [31:0] last_rdata = '0;
    logic        last_fault = 1'b0;
    logic [7:0]  mm [logic [AW-1:0]];

    typedef struct {
        logic [31:0] rd;
        logic        flt;
        int          due;
    } exp_t;
    exp_t q[$];

    data_mem_ls #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_fault(rsp_fault)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edges <= edges + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference: byte-at-a-time access on a flat little-endian byte space, addresses wrap mod 2**AW.
    task automatic model_op(input logic we, input logic [1:0] sz, input logic uns,
                            input logic [AW-1:0] a, input logic [31:0] wd, input bit beat1_only,
                            output logic [31:0] rd, output logic flt, output bit spl);
        int n;
        logic [31:0] v;
        logic [AW-1:0] ba;
        n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
        flt = (sz == 2'd3);
`ifndef DATA_MEM_MISALIGN_EN
        if ((sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0)) flt = 1'b1;
`endif
        spl = !flt && (int'(a[1:0]) + n > 4);
        v = '0;
        rd = '0;
        if (!flt) begin
            for (int i = 0; i < n; i++) begin
                if (!beat1_only || int'(a[1:0]) + i < 4) begin
                    ba = a + AW'(i);
                    if (we) mm[ba] = wd[8*i +: 8];
                    else v[8*i +: 8] = mm.exists(ba) ? mm[ba] : 8'hxx;
                end
            end
            if (!we) begin
                case (sz)
                    2'd0:    rd = uns ? {24'h0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
                    2'd1:    rd = uns ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
                    default: rd = v;
                endcase
            end
        end
    endtask

    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [AW-1:0] a, input logic [31:0] wd);
        logic [31:0] rd;
        logic flt;
        bit spl;
        exp_t e;
        @(negedge clk); #2;
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        model_op(we, sz, uns, a, wd, 1'b0, rd, flt, spl);
        e.rd = rd; e.flt = flt; e.due = edges + (spl ? 1 : 0);
        q.push_back(e);
        if (spl) begin
            busy_edge = edges;
            @(negedge clk); #2;
            req_we = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
            req_addr = AW'($urandom); req_wdata = $urandom;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        for (int k = 0; k < 8 && q.size() != 0; k++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout: %0d responses outstanding, want 0", q.size());
            q.delete();
        end
    endtask

    // Per-cycle compare of handshake and response against the model's queue.
    always @(negedge clk) begin
        chk("req_ready", {31'b0, req_ready}, {31'b0, (!rst && edges != busy_edge)});
        if (q.size() != 0 && q[0].due == edges) begin
            chk("rsp_valid", {31'b0, rsp_valid}, 32'd1);
            chk("rsp_rdata", rsp_rdata, q[0].rd);
            chk("rsp_fault", {31'b0, rsp_fault}, {31'b0, q[0].flt});
            last_rdata = rsp_rdata;
            last_fault = rsp_fault;
            void'(q.pop_front());
        end else begin
            chk("rsp_valid_idle", {31'b0, rsp_valid}, 32'd0);
            if (rst) begin
                chk("rst_rdata", rsp_rdata, 32'd0);
                chk("rst_fault", {31'b0, rsp_fault}, 32'd0);
            end
        end
    end

    initial begin
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); #2 rst = 1'b0;

        for (int w = 0; w < 16; w++) issue(1, 2'd2, 0, AW'(32'h100 + 4*w), 32'hC0DE0000 | (32'h100 + 4*w));
        issue(1, 2'd2, 0, AW'(32'h1FFFC), 32'hC0DE_FFFC);
        issue(1, 2'd2, 0, AW'(32'h0), 32'hC0DE_0000);
        issue(1, 2'd2, 0, AW'(32'h200), 32'hC0DE_0200);
        wait_rsp();

        issue(1, 2'd2, 0, AW'(32'h100), 32'hDEADBEEF);
        issue(0, 2'd2, 0, AW'(32'h100), 32'h0); wait_rsp();
        chk("lw_100", last_rdata, 32'hDEADBEEF);
        chk("lw_100_fault", {31'b0, last_fault}, 32'd0);
        issue(0, 2'd0, 0, AW'(32'h103), 32'h0); wait_rsp();
        chk("lb_103", last_rdata, 32'hFFFFFFDE);
        issue(0, 2'd0, 1, AW'(32'h103), 32'h0); wait_rsp();
        chk("lbu_103", last_rdata, 32'h000000DE);
        issue(0, 2'd1, 0, AW'(32'h102), 32'h0); wait_rsp();
        chk("lh_102", last_rdata, 32'hFFFFDEAD);
        issue(1, 2'd0, 0, AW'(32'h101), 32'h55);
        issue(0, 2'd2, 0, AW'(32'h100), 32'h0); wait_rsp();
        chk("sb_lw_100", last_rdata, 32'hDEAD55EF);

        issue(1, 2'd3, 0, AW'(32'h100), 32'h0); wait_rsp();
        chk("rsvd_fault", {31'b0, last_fault}, 32'd1);
        chk("rsvd_rdata", last_rdata, 32'd0);
        issue(0, 2'd2, 0, AW'(32'h100), 32'h0); wait_rsp();
        chk("rsvd_nowrite", last_rdata, 32'hDEAD55EF);

        issue(1, 2'd2, 0, AW'(32'h200), 32'h11223344);
        issue(0, 2'd2, 0, AW'(32'h200), 32'h0); wait_rsp();
        chk("b2b_lw_200", last_rdata, 32'h11223344);

        issue(1, 2'd2, 0, AW'(32'h105), 32'hAABBCCDD);
        issue(0, 2'd2, 0, AW'(32'h105), 32'h0); wait_rsp();
`ifdef DATA_MEM_MISALIGN_EN
        chk("mis_lw_105", last_rdata, 32'hAABBCCDD);
        // Reset lands in the SPLIT cycle of a crossing store: only beat 1 (byte 0x107) sticks.
        @(negedge clk); #2;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = AW'(32'h107); req_wdata = 32'h99887766;
        @(posedge clk); #1;
        begin
            logic [31:0] rd; logic flt; bit spl;
            model_op(1, 2'd2, 0, AW'(32'h107), 32'h99887766, 1'b1, rd, flt, spl);
        end
        busy_edge = edges;
        req_valid = 1'b0;
        @(negedge clk); #2 rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); #2 rst = 1'b0;
        issue(0, 2'd2, 0, AW'(32'h104), 32'h0); wait_rsp();
        chk("rst_split_104", last_rdata, 32'h66CCDD04);
        issue(0, 2'd2, 0, AW'(32'h108), 32'h0); wait_rsp();
        chk("rst_split_108", last_rdata, 32'hC0DE01AA);

        issue(1, 2'd1, 0, AW'(32'h1FFFF), 32'h0000BEEF);
        issue(0, 2'd1, 1, AW'(32'h1FFFF), 32'h0); wait_rsp();
        chk("wrap_lhu", last_rdata, 32'h0000BEEF);
        issue(0, 2'd0, 1, AW'(32'h1FFFF), 32'h0); wait_rsp();
        chk("wrap_top_byte", last_rdata, 32'h000000EF);
        issue(0, 2'd0, 1, AW'(32'h0), 32'h0); wait_rsp();
        chk("wrap_byte0", last_rdata, 32'h000000BE);
`else
        chk("mis_lw_105_fault", {31'b0, last_fault}, 32'd1);
        issue(0, 2'd2, 0, AW'(32'h104), 32'h0); wait_rsp();
        chk("mis_keep_104", last_rdata, 32'hC0DE0104);
        issue(0, 2'd2, 0, AW'(32'h108), 32'h0); wait_rsp();
        chk("mis_keep_108", last_rdata, 32'hC0DE0108);
`endif

        for (int i = 0; i < 400; i++) begin
            logic [AW-1:0] a;
            if ($urandom_range(0, 9) == 0) a = AW'(32'h1FFFC + $urandom_range(0, 3));
            else a = AW'(32'h100 + $urandom_range(0, 59));
            issue(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom);
            if ($urandom_range(0, 7) == 0) begin
                @(negedge clk);
            end
        end
        wait_rsp();
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
